// File: rtl/rcv_deser.sv
// Serial link receiver: registers fs/d/bit-clock, samples on bit-clock falling edges
// and assembles MSB-first 16-bit words into a one-deep output buffer.
// Optional macro RCV_DESER_SYNC_EN adds a 2-flop synchronizer ahead of the edge-history flop.
module rcv_deser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fs,
  input  logic        i_d,
  input  logic        i_clk,
  output logic [15:0] o_rx_data,
  output logic        o_rx_vld,
  input  logic        i_rx_rdy,
  output logic        o_ovf,
  output logic        o_frm_err
);

  // state | meaning
  // IDLE  | waiting for fs=1 on a sample event
  // ARM   | frame sync seen; next fs=0 sample carries the word MSB
  // SHIFT | collecting bits 2..16 of the word
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int LNK_FS  = 2;
  localparam int LNK_D   = 1;
  localparam int LNK_CLK = 0;

  logic [2:0]  lnk_in;
  logic [2:0]  stg_q;
  logic [2:0]  hist_q;
  logic        smp_ev;
  logic        smp_fs;
  logic        smp_d;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        done_q, done_d;
  logic        frm_err_q, frm_err_d;
  logic [3:0]  bit_idx;

  logic [15:0] data_q;
  logic        vld_q;
  logic        ovf_q;
  logic        xfer;

  assign lnk_in = {i_fs, i_d, i_clk};

  // All three link signals share one pipeline so fs/d stay aligned with the bit clock.
`ifdef RCV_DESER_SYNC_EN
  logic [2:0] meta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      stg_q  <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= lnk_in;
      stg_q  <= meta_q;
      hist_q <= stg_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_q  <= '0;
      hist_q <= '0;
    end else begin
      stg_q  <= lnk_in;
      hist_q <= stg_q;
    end
  end
`endif

  // fs/d are taken from the history stage, i.e. from the last cycle the bit clock was high.
  assign smp_ev = hist_q[LNK_CLK] & ~stg_q[LNK_CLK];
  assign smp_fs = hist_q[LNK_FS];
  assign smp_d  = hist_q[LNK_D];

  assign bit_idx = 4'd15 - cnt_q[3:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (smp_ev) begin
      case (state_q)
        IDLE:    if (smp_fs) state_d = ARM;
        ARM:     if (!smp_fs) state_d = SHIFT;
        SHIFT: begin
          if (smp_fs)                  state_d = ARM;
          else if (cnt_q == 5'd15)     state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    frm_err_d = 1'b0;
    if (smp_ev) begin
      case (state_q)
        ARM: begin
          if (smp_fs) begin
            frm_err_d = 1'b1;
          end else begin
            shift_d = {smp_d, 15'd0};
            cnt_d   = 5'd1;
          end
        end
        SHIFT: begin
          if (cnt_q == 5'd15) begin
            // Final bit completes the word regardless of fs; fs only selects ARM vs IDLE.
            shift_d[0] = smp_d;
            cnt_d      = 5'd16;
            done_d     = 1'b1;
          end else if (smp_fs) begin
            frm_err_d = 1'b1;
            shift_d   = '0;
            cnt_d     = '0;
          end else begin
            shift_d[bit_idx] = smp_d;
            cnt_d            = cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign xfer = vld_q & i_rx_rdy;

  // One-deep output buffer: a finished word replaces the old one only if it leaves this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (done_q) begin
        if (!vld_q || xfer) begin
          data_q <= shift_q;
          vld_q  <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign o_rx_data = data_q;
  assign o_rx_vld  = vld_q;
  assign o_ovf     = ovf_q;
  assign o_frm_err = frm_err_q;

endmodule
